vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates raster timing for 800x600@60 (VESA) from the 40 MHz pixel clock out of the ECP5 PLL. Sits directly downstream of the PLL.
- Produces hsync, vsync, data-enable, and pixel coordinates for the video output stage.
- Produces an early fetch strobe so the pixel source (framebuffer/pattern logic) can pipeline reads ahead of display.
- At top level, reset is driven by the inverted PLL lock signal.

Parameters:
H_VISIBLE, 800, active pixels per line
H_FRONT, 40, horizontal front porch (pixels)
H_SYNC, 128, hsync pulse width (pixels)
H_BACK, 88, horizontal back porch (pixels)
V_VISIBLE, 600, active lines per frame
V_FRONT, 1, vertical front porch (lines)
V_SYNC, 4, vsync pulse width (lines)
V_BACK, 23, vertical back porch (lines)
H_SYNC_POL, 1, active level of hsync (1 = positive)
V_SYNC_POL, 1, active level of vsync
PREFETCH, 2, cycles by which fetch leads de; legal range 0..(H_TOTAL-H_VISIBLE)

Ports:
clock  in  1  pixel clock, 40 MHz
reset  in  1  asynchronous, active-high; top level ties it to !locked
hsync  out  1  horizontal sync, polarity H_SYNC_POL
vsync  out  1  vertical sync, polarity V_SYNC_POL
de  out  1  pixel is in visible area
x  out  XW  horizontal counter; XW = $clog2(H_TOTAL) = 11
y  out  YW  vertical counter; YW = $clog2(V_TOTAL) = 10
line_start  out  1  one-cycle pulse at x==0
frame_start  out  1  one-cycle pulse at x==0, y==0
fetch  out  1  request pixel (fetch_x, fetch_y)
fetch_x  out  XW  column to fetch
fetch_y  out  YW  row to fetch

Behaviour:
- Totals: H_TOTAL = sum of H_* widths = 1056. V_TOTAL = sum of V_* widths = 628.
- Reset, asynchronous and active-high. On assertion:
  - h_count = 0, v_count = 0.
  - Both phase FSMs go to ACTIVE.
  - Outputs: de = 0, line_start = 0, frame_start = 0, fetch = 0; x = y = fetch_x = fetch_y = 0.
  - hsync = !H_SYNC_POL, vsync = !V_SYNC_POL (inactive levels).
- Horizontal counter: h_count increments every cycle and wraps from H_TOTAL-1 to 0. Same behaviour mid-frame.
- Vertical counter: v_count increments when h_count wraps, and wraps from V_TOTAL-1 to 0.
- Horizontal FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Transitions occur at h_count = H_VISIBLE, +H_FRONT, +H_SYNC, and the wrap to 0.
- Vertical FSM: same four states, line-based. It advances only on the h_count wrap.
- Output timing:
  - All outputs are registered and show the state of the counters/FSMs from the previous cycle.
  - First clock edge after reset release: outputs show (0,0) with de = 1, line_start = 1, frame_start = 1.
- Signal decodes:
  - hsync is active exactly while the horizontal FSM is in SYNC.
  - vsync is active exactly while the vertical FSM is in SYNC. Its edges coincide with x == 0 (line boundary).
  - de = (H state == ACTIVE) && (V state == ACTIVE).
  - x and y are the raw counters and are valid during blanking as well.
- Prefetch:
  - Target column t = h_count + PREFETCH (mod H_TOTAL).
  - If h_count + PREFETCH >= H_TOTAL, the target row is v_count + 1 (mod V_TOTAL); otherwise it is v_count.
  - fetch = (t < H_VISIBLE) && (target row < V_VISIBLE); fetch_x = t, fetch_y = target row. Registered like the other outputs.
  - Consequence: fetch leads de by exactly PREFETCH cycles, including across line and frame wrap.
  - No fetch is issued in the last visible line for vblank rows.
  - Fetches for row 0 are issued at the end of line V_TOTAL-1.
- PREFETCH = 0: fetch is identical to de, and fetch_x/fetch_y are identical to x/y.
- Reset mid-frame: outputs take their reset values immediately (asynchronously). The raster restarts at (0,0) on release with no partial-line artefacts.
- Elaboration check: fail if PREFETCH > H_TOTAL - H_VISIBLE or if any porch/sync parameter is 0.

Test Plan:
- Reset release: hold reset 5 cycles, then release -> all outputs at reset values during reset. First edge after release: de = 1, x = 0, y = 0, frame_start = 1, line_start = 1, hsync = vsync = 0.
- Horizontal timing: run 3 lines -> line_start period 1056 cycles; de high 800 cycles per visible line; hsync high 128 cycles starting at x = 840, low at x = 968.
- Vertical timing: run 2 frames -> frame_start period 663168 cycles; vsync high for 4224 cycles starting at y = 601, x = 0; de high for exactly 480000 cycles per frame.
- Prefetch wrap: PREFETCH = 2 -> at x = 1054, y = 5: fetch = 1, fetch_x = 0, fetch_y = 6. At x = 798, y = 599: fetch = 0. At x = 1054, y = 627: fetch = 1, fetch_y = 0.
- PREFETCH = 0 variant: compare every cycle for a full frame -> fetch == de, fetch_x == x, fetch_y == y.
- Mid-frame reset: assert reset at x = 400, y = 300 for 3 cycles -> de drops the same cycle (async). After release the raster restarts at (0,0) and the next frame_start occurs 663168 cycles later.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VESA raster timing (default 800x600@60 at 40 MHz) with sync, data-enable,
// coordinates and a fetch strobe that leads de by PREFETCH cycles.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 800,
    parameter int H_FRONT    = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BACK     = 88,
    parameter int V_VISIBLE  = 600,
    parameter int V_FRONT    = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BACK     = 23,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1,
    parameter int PREFETCH   = 2,
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int XW        = $clog2(H_TOTAL),
    localparam int YW        = $clog2(V_TOTAL)
) (
    input  logic          clock,
    input  logic          reset,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          fetch,
    output logic [XW-1:0] fetch_x,
    output logic [YW-1:0] fetch_y
);

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

    localparam logic [XW-1:0] H_ACT_LAST   = XW'(H_VISIBLE - 1);
    localparam logic [XW-1:0] H_FRONT_LAST = XW'(H_VISIBLE + H_FRONT - 1);
    localparam logic [XW-1:0] H_SYNC_LAST  = XW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [XW-1:0] H_LAST       = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_LAST   = YW'(V_VISIBLE - 1);
    localparam logic [YW-1:0] V_FRONT_LAST = YW'(V_VISIBLE + V_FRONT - 1);
    localparam logic [YW-1:0] V_SYNC_LAST  = YW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [YW-1:0] V_LAST       = YW'(V_TOTAL - 1);

    if (PREFETCH < 0 || PREFETCH > H_TOTAL - H_VISIBLE || H_FRONT == 0 || H_SYNC == 0 ||
        H_BACK == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameters");
    end

    logic [XW-1:0] h_count, h_count_next;
    logic [YW-1:0] v_count, v_count_next, v_inc;
    phase_t        h_state, h_state_next, v_state, v_state_next;
    logic          h_wrap;

    assign h_wrap = h_count == H_LAST;
    assign v_inc  = (v_count == V_LAST) ? '0 : v_count + 1'b1;

    always_comb begin
        h_count_next = h_wrap ? '0 : h_count + 1'b1;
        v_count_next = h_wrap ? v_inc : v_count;
    end

    always_comb begin
        h_state_next = h_state;
        case (h_state)
            ACTIVE: if (h_count == H_ACT_LAST) h_state_next = FRONT;
            FRONT:  if (h_count == H_FRONT_LAST) h_state_next = SYNC;
            SYNC:   if (h_count == H_SYNC_LAST) h_state_next = BACK;
            BACK:   if (h_wrap) h_state_next = ACTIVE;
        endcase
    end

    // The vertical phase only moves on the last pixel of a line, so vsync edges land on x == 0.
    always_comb begin
        v_state_next = v_state;
        case (v_state)
            ACTIVE: if (h_wrap && v_count == V_ACT_LAST) v_state_next = FRONT;
            FRONT:  if (h_wrap && v_count == V_FRONT_LAST) v_state_next = SYNC;
            SYNC:   if (h_wrap && v_count == V_SYNC_LAST) v_state_next = BACK;
            BACK:   if (h_wrap && v_count == V_LAST) v_state_next = ACTIVE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
            h_state <= ACTIVE;
            v_state <= ACTIVE;
        end else begin
            h_count <= h_count_next;
            v_count <= v_count_next;
            h_state <= h_state_next;
            v_state <= v_state_next;
        end
    end

    // Fetch target: the raster position PREFETCH pixels ahead, rolling into the next row/frame.
    logic [XW:0]   f_sum;
    logic          f_wrap;
    logic [XW-1:0] f_col;
    logic [YW-1:0] f_row;

    always_comb begin
        f_sum  = {1'b0, h_count} + (XW + 1)'(PREFETCH);
        f_wrap = f_sum >= (XW + 1)'(H_TOTAL);
        f_col  = f_wrap ? XW'(f_sum - (XW + 1)'(H_TOTAL)) : XW'(f_sum);
        f_row  = f_wrap ? v_inc : v_count;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            fetch       <= 1'b0;
            fetch_x     <= '0;
            fetch_y     <= '0;
        end else begin
            hsync       <= (h_state == SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync       <= (v_state == SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            de          <= h_state == ACTIVE && v_state == ACTIVE;
            x           <= h_count;
            y           <= v_count;
            line_start  <= h_count == '0;
            frame_start <= h_count == '0 && v_count == '0;
            fetch       <= f_col < XW'(H_VISIBLE) && f_row < YW'(V_VISIBLE);
            fetch_x     <= f_col;
            fetch_y     <= f_row;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench comparing three parameterisations of vga_timing_gen
// against a counter-range raster model, plus directed period/width/prefetch checks.
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, p;
        bit hp, vp;
    } cfg_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        hs0, vs0, de0, ls0, fs0, f0;
    logic [10:0] x0, fx0;
    logic [9:0]  y0, fy0;
    logic        hs1, vs1, de1, ls1, fs1, f1;
    logic [4:0]  x1, fx1;
    logic [3:0]  y1, fy1;
    logic        hs2, vs2, de2, ls2, fs2, f2;
    logic [4:0]  x2, fx2;
    logic [3:0]  y2, fy2;

    vga_timing_gen d0 (
        .clock(clk), .reset(rst), .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
        .line_start(ls0), .frame_start(fs0), .fetch(f0), .fetch_x(fx0), .fetch_y(fy0)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PREFETCH(2)
    ) d1 (
        .clock(clk), .reset(rst), .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
        .line_start(ls1), .frame_start(fs1), .fetch(f1), .fetch_x(fx1), .fetch_y(fy1)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3), .PREFETCH(0)
    ) d2 (
        .clock(clk), .reset(rst), .hsync(hs2), .vsync(vs2), .de(de2), .x(x2), .y(y2),
        .line_start(ls2), .frame_start(fs2), .fetch(f2), .fetch_x(fx2), .fetch_y(fy2)
    );

    logic [47:0] obs [3];
    assign obs[0] = {hs0, vs0, de0, ls0, fs0, f0, x0, y0, fx0, fy0};
    assign obs[1] = {hs1, vs1, de1, ls1, fs1, f1, 11'(x1), 10'(y1), 11'(fx1), 10'(fy1)};
    assign obs[2] = {hs2, vs2, de2, ls2, fs2, f2, 11'(x2), 10'(y2), 11'(fx2), 10'(fy2)};

    cfg_t cfg [3];
    int   mh [3];
    int   mv [3];
    logic [2:0][47:0] sb_q [$];

    int checks = 0, passed = 0, cyc = 0;
    int last_ls0 = -1, hs0_cnt = 0, de0_cnt = 0;
    int last_fs1 = -1, vs1_cnt = 0, de1_cnt = 0;

    task automatic check(string tag, logic [47:0] got, logic [47:0] want);
        checks++;
        assert (got === want) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, want);
    endtask

    // Expected outputs for the raster position (h, v), derived from range tests and a linear pixel index.
    function automatic logic [47:0] model(int i);
        cfg_t c  = cfg[i];
        int h    = mh[i];
        int v    = mv[i];
        int ht   = c.hv + c.hf + c.hs + c.hb;
        int vt   = c.vv + c.vf + c.vs + c.vb;
        int idx  = (v * ht + h + c.p) % (ht * vt);
        int fx   = idx % ht;
        int fy   = idx / ht;
        logic hs = (h >= c.hv + c.hf && h < c.hv + c.hf + c.hs) ? c.hp : !c.hp;
        logic vs = (v >= c.vv + c.vf && v < c.vv + c.vf + c.vs) ? c.vp : !c.vp;
        return {hs, vs, h < c.hv && v < c.vv, h == 0, h == 0 && v == 0, fx < c.hv && fy < c.vv,
                11'(h), 10'(v), 11'(fx), 10'(fy)};
    endfunction

    task automatic advance(int i);
        mh[i]++;
        if (mh[i] == cfg[i].hv + cfg[i].hf + cfg[i].hs + cfg[i].hb) begin
            mh[i] = 0;
            mv[i]++;
            if (mv[i] == cfg[i].vv + cfg[i].vf + cfg[i].vs + cfg[i].vb) mv[i] = 0;
        end
    endtask

    task automatic tick();
        logic [2:0][47:0] e;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                e[i]  = {!cfg[i].hp, !cfg[i].vp, 46'd0};
                mh[i] = 0;
                mv[i] = 0;
            end else begin
                e[i] = model(i);
                advance(i);
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        cyc++;
        for (int i = 0; i < 3; i++) check($sformatf("dut%0d_outputs", i), obs[i], e[i]);
        check("p0_fetch_eq_de", 48'({f2, fx2, fy2}), 48'({de2, x2, y2}));
        if (rst) begin
            last_ls0 = -1; hs0_cnt = 0; de0_cnt = 0;
            last_fs1 = -1; vs1_cnt = 0; de1_cnt = 0;
        end
        if (ls0) begin
            if (last_ls0 >= 0) begin
                check("d0_line_period", 48'(cyc - last_ls0), 48'd1056);
                check("d0_hsync_width", 48'(hs0_cnt), 48'd128);
                check("d0_de_per_line", 48'(de0_cnt), 48'd800);
            end
            last_ls0 = cyc; hs0_cnt = 0; de0_cnt = 0;
        end
        hs0_cnt += int'(hs0);
        de0_cnt += int'(de0);
        if (fs1) begin
            if (last_fs1 >= 0) begin
                check("d1_frame_period", 48'(cyc - last_fs1), 48'd400);
                check("d1_vsync_cycles", 48'(vs1_cnt), 48'd50);
                check("d1_de_per_frame", 48'(de1_cnt), 48'd160);
            end
            last_fs1 = cyc; vs1_cnt = 0; de1_cnt = 0;
        end
        vs1_cnt += int'(!vs1);
        de1_cnt += int'(de1);
        if (x1 == 5'd14 && y1 == 4'd9) check("d1_no_fetch_vblank", 48'(f1), 48'd0);
        if (x1 == 5'd23 && y1 == 4'd15) check("d1_fetch_frame_wrap", 48'({f1, fx1, fy1}), 48'({1'b1, 5'd0, 4'd0}));
    endtask

    initial begin
        bit found;
        cfg[0] = '{800, 40, 128, 88, 600, 1, 4, 23, 2, 1'b1, 1'b1};
        cfg[1] = '{16, 2, 4, 3, 10, 1, 2, 3, 2, 1'b0, 1'b0};
        cfg[2] = '{16, 2, 4, 3, 10, 1, 2, 3, 0, 1'b1, 1'b1};
        rst = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        check("first_edge", 48'({de0, ls0, fs0, hs0, vs0, x0, y0}), 48'({5'b11100, 21'd0}));
        found = 1'b0;
        for (int n = 0; n < 7000 && !found; n++) begin
            tick();
            found = x0 == 11'd1054 && y0 == 10'd5;
        end
        check("d0_reach_1054_5", 48'(found), 48'd1);
        if (found) check("d0_fetch_line_wrap", 48'({f0, fx0, fy0}), 48'({1'b1, 11'd0, 10'd6}));
        found = 1'b0;
        for (int n = 0; n < 500 && !found; n++) begin
            tick();
            found = x1 == 5'd8 && y1 == 4'd5;
        end
        check("d1_reach_8_5", 48'(found), 48'd1);
        check("pre_reset_de", 48'({de1, de2}), 48'b11);
        rst = 1'b1;
        #1;
        check("async_reset", 48'({de0, de1, de2, x1, y1, fs1}), 48'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("restart_origin", 48'({fs1, ls1, de1, x1, y1}), 48'({3'b111, 9'd0}));
        repeat (850) tick();
        check("frames_after_reset", 48'(last_fs1 > 0 && cyc - last_fs1 < 400), 48'd1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
